// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register, data-memory handshake, store lane alignment and load extraction.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_access_stage #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_store_data,
    input  logic [2:0]        ex_func3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              stall,
    output logic [4:0]        MEM_RegRd,
    output logic              MEM_RegWrite,
    output logic [31:0]       DM_address,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_bweb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ready,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              mem_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t            state_q;
    logic              valid_q, mr_q, mw_q, rw_q;
    logic [31:0]       alu_q, sd_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              req_q, we_q, wb_we_q, fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        bweb_q;
    logic [31:0]       wdata_q, wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              mem_op, store, wr_en, trap, issue, ld_done, done;
    logic [1:0]        lo;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [3:0]        bweb_d;
    logic [31:0]       wdata_d, ld_d;

    assign mem_op  = valid_q & (mr_q | mw_q);
    assign store   = mw_q & ~mr_q;
    assign wr_en   = rw_q & |rd_q;
`ifdef MISALIGN_TRAP_EN
    assign trap    = mem_op && state_q == IDLE && (f3_q[1] ? |alu_q[1:0] : f3_q[0] & alu_q[0]);
`else
    assign trap    = 1'b0;
`endif
    assign issue   = state_q == IDLE && mem_op && !trap;
    assign ld_done = mr_q && ((state_q == REQ && dm_ready && dm_rvalid) || (state_q == WAIT && dm_rvalid));
    assign done    = (state_q == REQ && dm_ready && store) || ld_done;
    // Drops in the cycle the handshake completes so EX advances without a dead cycle.
    assign stall   = issue || (state_q != IDLE && !done);
    assign lo      = f3_q[1] ? 2'b00 : {alu_q[1], alu_q[0] & ~f3_q[0]};
    assign bweb_d  = f3_q[1] ? 4'b0000 : f3_q[0] ? (lo[1] ? 4'b0011 : 4'b1100) : ~(4'b0001 << lo);
    assign wdata_d = f3_q[1] ? sd_q : f3_q[0] ? {2{sd_q[15:0]}} : {4{sd_q[7:0]}};
    assign b       = dm_rdata[{lo, 3'b000} +: 8];
    assign h       = dm_rdata[{lo[1], 4'b0000} +: 16];
    assign ld_d    = f3_q[1] ? dm_rdata : f3_q[0] ? {{16{h[15] & ~f3_q[2]}}, h} : {{24{b[7] & ~f3_q[2]}}, b};

    assign MEM_RegRd    = rd_q;
    assign MEM_RegWrite = valid_q & wr_en & ~mr_q;
    assign DM_address   = alu_q;
    assign dm_req       = req_q;
    assign dm_we        = we_q;
    assign dm_addr      = addr_q;
    assign dm_bweb      = bweb_q;
    assign dm_wdata     = wdata_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_we_q;
    assign mem_fault    = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            rw_q      <= 1'b0;
            alu_q     <= '0;
            sd_q      <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            bweb_q    <= 4'hF;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (!stall) begin
                valid_q <= ex_valid;
                mr_q    <= ex_mem_read;
                mw_q    <= ex_mem_write;
                rw_q    <= ex_reg_write;
                alu_q   <= ex_alu_out;
                sd_q    <= ex_store_data;
                f3_q    <= ex_func3;
                rd_q    <= ex_rd;
            end
            wb_we_q <= 1'b0;
            fault_q <= trap;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= store;
                        addr_q  <= alu_q[ADDR_W+1:2];
                        bweb_q  <= store ? bweb_d : 4'hF;
                        wdata_q <= wdata_d;
                    end else if (valid_q && !mem_op) begin
                        wb_data_q <= alu_q;
                        wb_rd_q   <= rd_q;
                        wb_we_q   <= wr_en;
                    end
                end
                REQ: begin
                    if (dm_ready) begin
                        state_q <= (mr_q && !dm_rvalid) ? WAIT : IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        bweb_q  <= 4'hF;
                    end
                end
                default: if (dm_rvalid) state_q <= IDLE;
            endcase
            if (ld_done) begin
                wb_data_q <= ld_d;
                wb_rd_q   <= rd_q;
                wb_we_q   <= wr_en;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
    logic        clk = 1'b0, rst = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_reg_write = 1'b0;
    logic [31:0] ex_alu_out = '0, ex_store_data = '0;
    logic [2:0]  ex_func3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        dm_ready = 1'b0, dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        stall, MEM_RegWrite, dm_req, dm_we, wb_reg_write, mem_fault;
    logic [4:0]  MEM_RegRd, wb_rd;
    logic [31:0] DM_address, dm_wdata, wb_data;
    logic [13:0] dm_addr;
    logic [3:0]  dm_bweb;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_func3(ex_func3), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .stall(stall),
        .MEM_RegRd(MEM_RegRd), .MEM_RegWrite(MEM_RegWrite), .DM_address(DM_address),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_bweb(dm_bweb), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_fault(mem_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction through MEM; memory accepts after rlat cycles, returns data vlat cycles later.
    task automatic run_op(input logic [2:0] f3, input logic mr, input logic mw, input logic rw,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int rlat, input int vlat);
        int          sz, lane, ns;
        logic        memop, trap, wen;
        logic [31:0] ea, wd, val, eaddr;
        logic [3:0]  bw;
        logic [63:0] raw;
        sz    = f3[1] ? 4 : (f3[0] ? 2 : 1);
        memop = mr | mw;
`ifdef MISALIGN_TRAP_EN
        trap  = memop && (a % sz != 0);
`else
        trap  = 1'b0;
`endif
        ea    = a - (a % sz);
        lane  = int'(ea % 4);
        eaddr = (ea / 4) % 16384;
        bw    = 4'hF;
        for (int i = 0; i < sz; i++) bw[lane + i] = 1'b0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
        raw = (64'(rdat) >> (8 * lane)) & ((64'd1 << (8 * sz)) - 64'd1);
        if (!f3[2] && sz < 4 && raw[8*sz-1]) raw = raw - (64'd1 << (8 * sz));
        val = raw[31:0];
        wen = rw && rd != 5'd0;
        ex_valid = 1'b1; ex_alu_out = a; ex_store_data = sd; ex_func3 = f3;
        ex_mem_read = mr; ex_mem_write = mw; ex_rd = rd; ex_reg_write = rw;
        dm_ready = 1'b0; dm_rvalid = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("mem_regrd", MEM_RegRd, rd);
        chk("dm_address", DM_address, a);
        chk("mem_regwrite", MEM_RegWrite, wen && !mr);
        chk("wb_pulse", wb_reg_write, 0);
        chk("fault_pulse", mem_fault, 0);
        if (!memop || trap) begin
            chk("stall_1cyc", stall, 0);
            chk("no_req", dm_req, 0);
            @(posedge clk); #1;
        end else begin
            ns = 0;
            chk("req_idle", dm_req, 0);
            dm_rvalid = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
            #1; ns += int'(stall);
            @(posedge clk); #1;
            for (int i = 0; i <= rlat; i++) begin
                chk("req", dm_req, 1);
                chk("we", dm_we, mw);
                chk("addr", dm_addr, eaddr);
                chk("bweb", dm_bweb, mw ? bw : 4'hF);
                if (mw) chk("wdata", dm_wdata, wd);
                dm_ready  = (i == rlat);
                dm_rvalid = (i < rlat) ? 1'($urandom_range(0, 1)) : (mr && vlat == 0);
                dm_rdata  = (i == rlat && vlat == 0) ? rdat : $urandom;
                #1; ns += int'(stall);
                @(posedge clk); #1;
            end
            dm_ready = 1'b0; dm_rvalid = 1'b0;
            if (mr) for (int i = 1; i <= vlat; i++) begin
                dm_rvalid = (i == vlat);
                dm_rdata  = (i == vlat) ? rdat : $urandom;
                #1; ns += int'(stall);
                @(posedge clk); #1;
            end
            dm_rvalid = 1'b0;
            chk("stall_cycles", ns, mr ? 1 + rlat + vlat : 1 + rlat);
        end
        chk("wb_we", wb_reg_write, !trap && !(memop && !mr) && wen);
        if (!memop || (mr && !trap)) begin
            chk("wb_data", wb_data, memop ? val : a);
            chk("wb_rd", wb_rd, rd);
        end
        chk("mem_fault", mem_fault, trap);
        chk("req_off", dm_req, 0);
        chk("bweb_off", dm_bweb, 4'hF);
    endtask

    initial begin
        logic [2:0] lf3 [5];
        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_bweb", dm_bweb, 4'hF);
        chk("rst_wb_we", wb_reg_write, 0);
        chk("rst_memrw", MEM_RegWrite, 0);
        chk("rst_fault", mem_fault, 0);
        chk("rst_dmaddress", DM_address, 0);
        rst = 1'b1;
        run_op(3'b000, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0, 0);
        run_op(3'b000, 0, 1, 0, 5'd0, 32'h103, 32'hAB, 0, 1, 0);
        run_op(3'b000, 1, 0, 1, 5'd9, 32'h102, 0, 32'h0080_0000, 3, 1);
        run_op(3'b101, 1, 0, 1, 5'd3, 32'h2, 0, 32'h8001_0000, 0, 0);
        run_op(3'b010, 1, 0, 1, 5'd4, 32'h6, 0, 32'hCAFE_F00D, 0, 1);
        run_op(3'b001, 0, 1, 0, 5'd0, 32'h206, 32'h1234_BEEF, 0, 2, 0);
        run_op(3'b000, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0);
        // Reset while a load waits for its data.
        ex_valid = 1'b1; ex_alu_out = 32'h10; ex_func3 = 3'b010;
        ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_rd = 5'd7; ex_reg_write = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", dm_req, 1);
        dm_ready = 1'b1;
        @(posedge clk); #1;
        dm_ready = 1'b0;
        chk("pre_rst_stall", stall, 1);
        rst = 1'b0; #1;
        chk("arst_req", dm_req, 0);
        chk("arst_stall", stall, 0);
        chk("arst_wb_we", wb_reg_write, 0);
        chk("arst_bweb", dm_bweb, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int   k;
            logic [4:0] rd;
            k  = int'($urandom_range(0, 2));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (k == 0)
                run_op(3'($urandom_range(0, 7)), 0, 0, 1'($urandom_range(0, 1)), rd, $urandom, $urandom, 0, 0, 0);
            else if (k == 1)
                run_op(lf3[$urandom_range(0, 4)], 1, 0, 1'($urandom_range(0, 1)), rd, $urandom, 0, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            else
                run_op(3'($urandom_range(0, 2)), 0, 1, 0, rd, $urandom, $urandom, 0, int'($urandom_range(0, 3)), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
